// File: rtl/cva6_clic_irq_arbiter.sv
// ---------------------------------------------------------------------------
// cva6_clic_irq_arbiter
//
// Collects NumSrc interrupt lines and picks the eligible source with the
// highest level (ties go to the lowest id). It offers that source to the core
// with a valid/ready handshake and pulses irq_claim_o once the core accepts.
//
// Pipeline (level mode): source register -> candidate register -> offer FSM,
// so a source seen high before edge k is offered after edge k+2.
//
// Optional feature: define CVA6_CLIC_EDGE_EN to build edge-triggered pending
// bits. An edge source is then offered one cycle later than a level source.
// Without the macro, irq_trig_i is ignored and every source is level mode.
// ---------------------------------------------------------------------------
module cva6_clic_irq_arbiter #(
  parameter  int unsigned NumSrc     = 256,
  parameter  int unsigned LevelWidth = 8,
  localparam int unsigned IdWidth    = $clog2(NumSrc)
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic [NumSrc-1:0]            irq_src_i,
  input  logic [NumSrc-1:0]            irq_ie_i,
  input  logic [NumSrc*LevelWidth-1:0] irq_level_i,
  input  logic [NumSrc-1:0]            irq_trig_i,
  input  logic [LevelWidth-1:0]        threshold_i,
  output logic                         irq_valid_o,
  output logic [IdWidth-1:0]           irq_id_o,
  output logic [LevelWidth-1:0]        irq_level_o,
  input  logic                         irq_ready_i,
  output logic                         irq_claim_o
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_OFFER = 2'd1,
    ST_CLAIM = 2'd2
  } state_e;

  // Registered source lines and the derived pending vector
  logic [NumSrc-1:0]     r_src;
  logic [NumSrc-1:0]     w_pend;
  logic [NumSrc-1:0]     w_elig;

  // Combinational winner of this cycle
  logic                  w_win_valid;
  logic [IdWidth-1:0]    w_win_id;
  logic [LevelWidth-1:0] w_win_level;

  // Candidate registers (winner delayed by one cycle)
  logic                  r_cand_valid;
  logic [IdWidth-1:0]    r_cand_id;
  logic [LevelWidth-1:0] r_cand_level;

  // Offer FSM state and registered outputs
  state_e                r_state;
  logic                  r_valid;
  logic [IdWidth-1:0]    r_id;
  logic [LevelWidth-1:0] r_level;
  logic                  r_claim;

  // Sample the raw source lines once per cycle
  // NOTE: sequential state uses non-blocking assignments so every register
  // in the same edge sees the pre-edge value of every other register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_src <= '0;
    end else begin
      r_src <= irq_src_i;
    end
  end

`ifdef CVA6_CLIC_EDGE_EN
  // Edge-mode pending logic: previous sample, arming and sticky pending bits
  logic [NumSrc-1:0] r_src_d;
  logic [NumSrc-1:0] r_edge_pend;
  logic [1:0]        r_arm;
  logic [NumSrc-1:0] w_rise;
  logic [NumSrc-1:0] w_claim_clr;

  // Rising edges only count once r_src_d holds a real post-reset sample, so
  // a line that went high during reset does not produce a phantom edge.
  assign w_rise = r_src & ~r_src_d & irq_trig_i & {NumSrc{r_arm[1]}};

  // One-hot clear of the id being claimed in the CLAIM cycle
  always_comb begin
    w_claim_clr = '0;
    for (int i = 0; i < int'(NumSrc); i++) begin
      w_claim_clr[i] = r_claim && (r_id == IdWidth'(i));
    end
  end

  // Track previous sample, arm after two post-reset edges, set/clear pending
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_src_d     <= '0;
      r_edge_pend <= '0;
      r_arm       <= '0;
    end else begin
      r_src_d     <= r_src;
      r_arm       <= {r_arm[0], 1'b1};
      // A new edge wins over the claim clear of the same id.
      r_edge_pend <= w_rise | (r_edge_pend & ~w_claim_clr);
    end
  end

  // The id being claimed is hidden from arbitration in the CLAIM cycle so
  // the stale candidate cannot re-offer it, unless a new edge arrived.
  assign w_pend = (irq_trig_i & r_edge_pend & ~(w_claim_clr & ~w_rise))
                | (~irq_trig_i & r_src);
`else
  // Level mode only: pending is the registered source line
  logic w_unused_trig;
  assign w_unused_trig = ^irq_trig_i;
  assign w_pend        = r_src;
`endif

  // Eligibility: pending, enabled and strictly above the threshold
  always_comb begin
    w_elig = '0;
    for (int i = 0; i < int'(NumSrc); i++) begin
      w_elig[i] = w_pend[i] && irq_ie_i[i]
               && (irq_level_i[i*LevelWidth +: LevelWidth] > threshold_i);
    end
  end

  // Highest level wins; scanning from the top id with >= lets a lower id
  // overwrite an equal level, which implements lowest-id tie-breaking.
  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    w_win_valid = 1'b0;
    w_win_id    = '0;
    w_win_level = '0;
    for (int i = int'(NumSrc) - 1; i >= 0; i--) begin
      if (w_elig[i] &&
          (!w_win_valid || (irq_level_i[i*LevelWidth +: LevelWidth] >= w_win_level))) begin
        w_win_valid = 1'b1;
        w_win_id    = IdWidth'(i);
        w_win_level = irq_level_i[i*LevelWidth +: LevelWidth];
      end
    end
  end

  // Register the winner as the candidate for the offer FSM
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cand_valid <= 1'b0;
      r_cand_id    <= '0;
      r_cand_level <= '0;
    end else begin
      r_cand_valid <= w_win_valid;
      r_cand_id    <= w_win_id;
      r_cand_level <= w_win_level;
    end
  end

  // Offer FSM with registered outputs: offer, replace, withdraw, claim
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= ST_IDLE;
      r_valid <= 1'b0;
      r_id    <= '0;
      r_level <= '0;
      r_claim <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_claim <= 1'b0;
          if (r_cand_valid) begin
            r_state <= ST_OFFER;
            r_valid <= 1'b1;
            r_id    <= r_cand_id;
            r_level <= r_cand_level;
          end
        end
        ST_OFFER: begin
          if (irq_ready_i) begin
            // Acceptance beats any pending replacement.
            r_state <= ST_CLAIM;
            r_valid <= 1'b0;
            r_claim <= 1'b1;
          end else if (r_cand_valid && (r_cand_level > r_level)) begin
            r_id    <= r_cand_id;
            r_level <= r_cand_level;
          end else if (!w_elig[r_id]) begin
            r_state <= ST_IDLE;
            r_valid <= 1'b0;
          end
        end
        ST_CLAIM: begin
          r_state <= ST_IDLE;
          r_valid <= 1'b0;
          r_claim <= 1'b0;
        end
        default: begin
          r_state <= ST_IDLE;
          r_valid <= 1'b0;
          r_claim <= 1'b0;
        end
      endcase
    end
  end

  assign irq_valid_o = r_valid;
  assign irq_id_o    = r_id;
  assign irq_level_o = r_level;
  assign irq_claim_o = r_claim;

endmodule

// File: tb/tb_cva6_clic_irq_arbiter.sv
// ---------------------------------------------------------------------------
// tb_cva6_clic_irq_arbiter
//
// Directed scenarios (latency, tie, preemption, withdraw, edge claim/race)
// followed by randomized traffic. A behavioural model that keeps the offer
// outputs as its own state predicts every cycle's outputs.
// Edge scenarios are built only with CVA6_CLIC_EDGE_EN defined.
// ---------------------------------------------------------------------------
module tb_cva6_clic_irq_arbiter;

  localparam int NS = 256;
  localparam int LW = 8;
  localparam int IW = 8;

`ifdef CVA6_CLIC_EDGE_EN
  localparam bit EdgeEn = 1'b1;
`else
  localparam bit EdgeEn = 1'b0;
`endif

  logic              clk_i = 1'b0;
  logic              rst_ni;
  logic [NS-1:0]     irq_src_i;
  logic [NS-1:0]     irq_ie_i;
  logic [NS*LW-1:0]  irq_level_i;
  logic [NS-1:0]     irq_trig_i;
  logic [LW-1:0]     threshold_i;
  logic              irq_valid_o;
  logic [IW-1:0]     irq_id_o;
  logic [LW-1:0]     irq_level_o;
  logic              irq_ready_i;
  logic              irq_claim_o;

  always #5 clk_i = ~clk_i;

  cva6_clic_irq_arbiter #(.NumSrc(NS), .LevelWidth(LW)) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .irq_src_i   (irq_src_i),
    .irq_ie_i    (irq_ie_i),
    .irq_level_i (irq_level_i),
    .irq_trig_i  (irq_trig_i),
    .threshold_i (threshold_i),
    .irq_valid_o (irq_valid_o),
    .irq_id_o    (irq_id_o),
    .irq_level_o (irq_level_o),
    .irq_ready_i (irq_ready_i),
    .irq_claim_o (irq_claim_o)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Offer outputs double as the model state: valid means offering,
  // claim means the claim cycle, neither means idle.
  bit m_src   [NS];
  bit m_prev  [NS];
  bit m_epend [NS];
  int m_edges;
  bit m_cv;
  int m_cid;
  int m_clv;
  bit m_valid;
  bit m_claim;
  int m_id;
  int m_lvl;

  function automatic int lvl_of(input int i);
    return int'(irq_level_i[i*LW +: LW]);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NS; i++) begin
      m_src[i] = 0; m_prev[i] = 0; m_epend[i] = 0;
    end
    m_edges = 0; m_cv = 0; m_cid = 0; m_clv = 0;
    m_valid = 0; m_claim = 0; m_id = 0; m_lvl = 0;
  endtask

  task automatic model_update();
    bit elig [NS];
    bit rise [NS];
    bit pend;
    int best_score;
    int best;
    int score;
    best_score = -1;
    best = 0;
    for (int i = 0; i < NS; i++) begin
      rise[i] = EdgeEn && irq_trig_i[i] && (m_edges >= 2) && m_src[i] && !m_prev[i];
      if (EdgeEn && irq_trig_i[i])
        pend = m_epend[i] && !(m_claim && (m_id == i) && !rise[i]);
      else
        pend = m_src[i];
      elig[i] = pend && irq_ie_i[i] && (lvl_of(i) > int'(threshold_i));
      if (elig[i]) begin
        score = lvl_of(i) * NS + (NS - 1 - i);
        if (score > best_score) begin
          best_score = score;
          best = i;
        end
      end
    end
    for (int i = 0; i < NS; i++) begin
      if (rise[i]) m_epend[i] = 1;
      else if (m_claim && (m_id == i)) m_epend[i] = 0;
    end
    if (m_claim) begin
      m_claim = 0;
    end else if (m_valid) begin
      if (irq_ready_i) begin
        m_valid = 0;
        m_claim = 1;
      end else if (m_cv && (m_clv > m_lvl)) begin
        m_id  = m_cid;
        m_lvl = m_clv;
      end else if (!elig[m_id]) begin
        m_valid = 0;
      end
    end else if (m_cv) begin
      m_valid = 1;
      m_id    = m_cid;
      m_lvl   = m_clv;
    end
    m_cv  = (best_score >= 0);
    m_cid = best;
    m_clv = lvl_of(best);
    for (int i = 0; i < NS; i++) begin
      m_prev[i] = m_src[i];
      m_src[i]  = irq_src_i[i];
    end
    if (m_edges < 2) m_edges++;
  endtask

  task automatic compare_model();
    check("valid", 32'(irq_valid_o), 32'(m_valid));
    check("claim", 32'(irq_claim_o), 32'(m_claim));
    if (m_valid) begin
      check("id", 32'(irq_id_o), 32'(m_id));
      check("level", 32'(irq_level_o), 32'(m_lvl));
    end
    if (!rst_ni) begin
      check("rst_id", 32'(irq_id_o), 32'd0);
      check("rst_level", 32'(irq_level_o), 32'd0);
    end
  endtask

  // One clock: model advances on the rising edge, outputs checked on the falling edge
  task automatic step();
    @(posedge clk_i);
    if (rst_ni) model_update();
    else        model_reset();
    @(negedge clk_i);
    compare_model();
  endtask

  task automatic clear_inputs();
    irq_src_i   = '0;
    irq_ie_i    = '0;
    irq_level_i = '0;
    irq_trig_i  = '0;
    threshold_i = '0;
    irq_ready_i = 1'b0;
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    clear_inputs();
    #1;
    model_reset();
    check("rst_valid", 32'(irq_valid_o), 32'd0);
    check("rst_claim", 32'(irq_claim_o), 32'd0);
    step();
    step();
    rst_ni = 1'b1;
    repeat (3) step();
  endtask

  task automatic set_src(input int id, input int lvl);
    irq_level_i[id*LW +: LW] = LW'(lvl);
    irq_ie_i[id]  = 1'b1;
    irq_src_i[id] = 1'b1;
  endtask

  task automatic wait_valid(input string tag, input int budget);
    int n;
    n = 0;
    while (!irq_valid_o && n < budget) begin
      step();
      n++;
    end
    if (!irq_valid_o) check({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  int pool [10] = '{0, 1, 2, 5, 12, 77, 128, 200, 254, 255};
  int claims;

  initial begin
    rst_ni = 1'b0;
    clear_inputs();

    // Level latency: high before edge k, offered after edge k+2; ready held
    // high throughout must be ignored while nothing is offered.
    do_reset();
    threshold_i = 8'h10;
    irq_ready_i = 1'b1;
    set_src(5, 8'h40);
    step();
    check("lvl_k0", 32'(irq_valid_o), 32'd0);
    step();
    check("lvl_k1", 32'(irq_valid_o), 32'd0);
    check("lvl_k1_claim", 32'(irq_claim_o), 32'd0);
    step();
    check("lvl_k2_valid", 32'(irq_valid_o), 32'd1);
    check("lvl_k2_id", 32'(irq_id_o), 32'd5);
    check("lvl_k2_level", 32'(irq_level_o), 32'h40);
    step();
    check("lvl_claim", 32'(irq_claim_o), 32'd1);
    check("lvl_claim_valid", 32'(irq_valid_o), 32'd0);

    // Threshold boundary: level equal to threshold is not eligible
    do_reset();
    threshold_i = 8'h40;
    set_src(6, 8'h40);
    repeat (4) step();
    check("thr_equal", 32'(irq_valid_o), 32'd0);

    // Tie: same level, lowest id wins
    do_reset();
    threshold_i = 8'h10;
    set_src(200, 8'h80);
    set_src(3, 8'h80);
    repeat (3) step();
    check("tie_valid", 32'(irq_valid_o), 32'd1);
    check("tie_id", 32'(irq_id_o), 32'd3);

    // Preemption: higher level replaces the live offer without dropping valid
    do_reset();
    threshold_i = 8'h10;
    set_src(3, 8'h20);
    repeat (3) step();
    check("pre_first_id", 32'(irq_id_o), 32'd3);
    set_src(7, 8'h90);
    for (int c = 0; c < 4; c++) begin
      step();
      check("pre_hold", 32'(irq_valid_o), 32'd1);
    end
    check("pre_id", 32'(irq_id_o), 32'd7);
    check("pre_level", 32'(irq_level_o), 32'h90);

    // Withdraw: offered source drops below threshold
    do_reset();
    threshold_i = 8'h10;
    set_src(9, 8'h40);
    repeat (3) step();
    check("wd_offer_id", 32'(irq_id_o), 32'd9);
    threshold_i = 8'hFF;
    step();
    check("wd_valid", 32'(irq_valid_o), 32'd0);
    check("wd_claim", 32'(irq_claim_o), 32'd0);
    step();
    check("wd_idle", 32'(irq_valid_o), 32'd0);

`ifdef CVA6_CLIC_EDGE_EN
    // Edge: one-cycle pulse, claim once, no re-offer
    do_reset();
    threshold_i = 8'h10;
    irq_trig_i[12] = 1'b1;
    set_src(12, 8'h50);
    step();
    irq_src_i[12] = 1'b0;
    step();
    check("edge_k1", 32'(irq_valid_o), 32'd0);
    step();
    check("edge_k2", 32'(irq_valid_o), 32'd0);
    step();
    check("edge_k3", 32'(irq_valid_o), 32'd1);
    check("edge_id", 32'(irq_id_o), 32'd12);
    irq_ready_i = 1'b1;
    step();
    irq_ready_i = 1'b0;
    check("edge_claim", 32'(irq_claim_o), 32'd1);
    claims = 0;
    for (int c = 0; c < 8; c++) begin
      step();
      if (irq_claim_o) claims++;
      check("edge_no_reoffer", 32'(irq_valid_o), 32'd0);
    end
    check("edge_extra_claims", 32'(claims), 32'd0);

    // Edge/claim race: new edge registered in the CLAIM cycle re-offers
    do_reset();
    threshold_i = 8'h10;
    irq_trig_i[12] = 1'b1;
    set_src(12, 8'h50);
    step();
    irq_src_i[12] = 1'b0;
    wait_valid("race_first", 8);
    check("race_first_id", 32'(irq_id_o), 32'd12);
    irq_src_i[12] = 1'b1;
    irq_ready_i   = 1'b1;
    step();
    check("race_claim", 32'(irq_claim_o), 32'd1);
    irq_src_i[12] = 1'b0;
    irq_ready_i   = 1'b0;
    wait_valid("race_reoffer", 8);
    check("race_reoffer_id", 32'(irq_id_o), 32'd12);
`endif

    // Mid-offer reset drops valid asynchronously
    do_reset();
    threshold_i = 8'h10;
    set_src(40, 8'h33);
    repeat (3) step();
    check("arst_pre", 32'(irq_valid_o), 32'd1);
    #2 rst_ni = 1'b0;
    #1;
    check("arst_valid", 32'(irq_valid_o), 32'd0);
    check("arst_id", 32'(irq_id_o), 32'd0);
    model_reset();
    step();
    rst_ni = 1'b1;

    // Randomized traffic on a pool of ids, including both ends of the range
    do_reset();
    threshold_i = LW'($urandom_range(0, 8'h40));
    foreach (pool[p]) begin
      irq_level_i[pool[p]*LW +: LW] = LW'($urandom_range(0, 255));
      irq_ie_i[pool[p]]   = ($urandom_range(0, 4) != 0);
      irq_trig_i[pool[p]] = $urandom_range(0, 1) == 1;
    end
    for (int c = 0; c < 3000; c++) begin
      int p;
      p = pool[$urandom_range(0, 9)];
      if ($urandom_range(0, 2) == 0) irq_src_i[p] = ~irq_src_i[p];
      if ($urandom_range(0, 15) == 0) irq_ie_i[pool[$urandom_range(0, 9)]] ^= 1'b1;
      if ($urandom_range(0, 15) == 0)
        irq_level_i[pool[$urandom_range(0, 9)]*LW +: LW] = LW'($urandom_range(0, 255));
      if ($urandom_range(0, 31) == 0) threshold_i = LW'($urandom_range(0, 8'h80));
      if ($urandom_range(0, 31) == 0) irq_trig_i[pool[$urandom_range(0, 9)]] ^= 1'b1;
      irq_ready_i = ($urandom_range(0, 3) == 0);
      if (c % 700 == 699) begin
        #2 rst_ni = 1'b0;
        #1;
        check("rnd_arst_valid", 32'(irq_valid_o), 32'd0);
        check("rnd_arst_claim", 32'(irq_claim_o), 32'd0);
        model_reset();
        step();
        rst_ni = 1'b1;
      end
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/cva6_clic_irq_arbiter.md
CVA6_CLIC_IRQ_ARBITER -- requirements
Module: cva6_clic_irq_arbiter

Interface
REQ-001 The block SHALL have parameter NumSrc, default 256: number of interrupt sources, legal range 2..1024.
REQ-002 The block SHALL have parameter LevelWidth, default 8: width of the per-source interrupt level.
REQ-003 The block SHALL have derived parameter IdWidth = $clog2(NumSrc); it is not overridable.
REQ-004 The block SHALL have port clk_i, input, 1: the single clock; all state is on its rising edge.
REQ-005 The block SHALL have port rst_ni, input, 1: asynchronous active-low reset.
REQ-006 The block SHALL have port irq_src_i, input, NumSrc: raw interrupt source lines.
REQ-007 The block SHALL have port irq_ie_i, input, NumSrc: per-source enable.
REQ-008 The block SHALL have port irq_level_i, input, NumSrc*LevelWidth: per-source level; source i occupies bits [i*LevelWidth +: LevelWidth].
REQ-009 The block SHALL have port irq_trig_i, input, NumSrc: per-source trigger mode; 1 = edge, 0 = level.
REQ-010 The block SHALL have port threshold_i, input, LevelWidth: minimum level; only levels strictly greater than this value are eligible.
REQ-011 The block SHALL have port irq_valid_o, output, 1: an interrupt is offered to the core.
REQ-012 The block SHALL have port irq_id_o, output, IdWidth: offered source id.
REQ-013 The block SHALL have port irq_level_o, output, LevelWidth: offered level.
REQ-014 The block SHALL have port irq_ready_i, input, 1: core accepts the offer.
REQ-015 The block SHALL have port irq_claim_o, output, 1: one-cycle pulse in the cycle after acceptance.

Function
REQ-016 In level mode, pending[i] SHALL equal the registered irq_src_i[i].
REQ-017 In edge mode, pending[i] SHALL be set on a registered 0->1 transition of irq_src_i[i] and SHALL be cleared in the CLAIM cycle of id i.
REQ-018 If an edge set and a CLAIM clear hit the same id in the same cycle, the set SHALL take priority.
REQ-019 Source i SHALL be eligible when pending[i] is 1, irq_ie_i[i] is 1, and its level is greater than threshold_i.
REQ-020 The winner SHALL be the eligible source with the highest level; level ties SHALL go to the lowest id.
REQ-021 The winner SHALL be registered each cycle into the candidate registers cand_valid, cand_id and cand_level.
REQ-022 The FSM SHALL have three states: IDLE, OFFER and CLAIM.
REQ-023 In IDLE, when cand_valid is 1, the FSM SHALL go to OFFER and latch cand_id and cand_level onto irq_id_o and irq_level_o.
REQ-024 In OFFER, irq_valid_o SHALL be 1.
REQ-025 In OFFER, when irq_ready_i is 1, the FSM SHALL go to CLAIM; acceptance has priority over replacement in the same cycle.
REQ-026 In OFFER without ready, a candidate with a strictly higher level than the offer SHALL replace the id and level while irq_valid_o stays 1.
REQ-027 In OFFER without ready, if the offered id is no longer eligible and no replacement applies, the FSM SHALL go to IDLE with irq_valid_o at 0.
REQ-028 CLAIM SHALL last exactly one cycle with irq_valid_o at 0 and irq_claim_o at 1, then return to IDLE.
REQ-029 Latency for a level-mode source SHALL be: source high before edge k -> irq_valid_o high after edge k+2.
REQ-030 Latency for an edge-mode source SHALL be one cycle longer than level mode.
REQ-031 irq_ready_i SHALL be ignored whenever irq_valid_o is 0.

Reset
REQ-032 While rst_ni is 0, the FSM SHALL be in IDLE and all pending, edge-sample and candidate registers SHALL be 0.
REQ-033 While rst_ni is 0, irq_valid_o, irq_id_o, irq_level_o and irq_claim_o SHALL be 0.
REQ-034 Reset asserted mid-offer SHALL drop irq_valid_o asynchronously.
REQ-035 Edges seen before or during reset SHALL be lost.

Configuration
REQ-036 With CVA6_CLIC_EDGE_EN defined, REQ-017, REQ-018 and REQ-030 SHALL apply.
REQ-037 Without CVA6_CLIC_EDGE_EN, no edge logic SHALL be built, irq_trig_i SHALL be ignored, and all sources SHALL behave as level mode.

Verification
REQ-038 Level test: src 5 at level 0x40, threshold 0x10, held high -> irq_valid_o=1, irq_id_o=5, irq_level_o=0x40 at edge k+2.
REQ-039 Tie test: src 3 and src 200 both at level 0x80, both asserted together -> id 3 offered.
REQ-040 Preemption test: offer id 3 at 0x20 with ready=0, then src 7 asserted at 0x90 -> id 7 replaces id 3, irq_valid_o never drops.
REQ-041 Withdraw test: with offer id 9 live, raise threshold_i to 0xFF -> irq_valid_o=0 and FSM back in IDLE.
REQ-042 Edge test (macro on): one-cycle pulse on src 12 with trig=1, then ready=1 -> single irq_claim_o pulse, and id 12 is not re-offered.
REQ-043 Edge/claim race test: a new src 12 edge lands in the CLAIM cycle -> id 12 is offered again.
